// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer trace drain controller.
// Trace entries are {rpt[7:0], data[23:0]}.
package la_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } la_state_e;

    localparam logic [1:0] TUSER_NONE  = 2'b00;
    localparam logic [1:0] TUSER_FLUSH = 2'b01;
    localparam logic [1:0] TUSER_TMO   = 2'b10;

    // RLE entry field offsets
    localparam int unsigned RPT_MSB  = 31;
    localparam int unsigned RPT_LSB  = 24;
    localparam int unsigned DATA_MSB = 23;
    localparam int unsigned DATA_LSB = 0;

    // Beat counter width (matches the 7-bit cfg_pop_cond)
    localparam int unsigned     CNT_W   = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clamp a FIFO level to what the beat counter can represent
    function automatic logic [CNT_W-1:0] sat_cnt(input int unsigned v);
        logic [CNT_W-1:0] r;
        if (v > 32'(CNT_MAX)) begin
            r = CNT_MAX;
        end else begin
            r = v[CNT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/la_drain_ctrl_if.sv
// AXI-Stream master link between the LA drain controller and the fabric.
interface la_drain_ctrl_if #(
    parameter int unsigned pDATA_WIDTH = 32
);
    logic [pDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tlast;
    logic [1:0]             tuser;
    logic                   tready;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/la_hpri_hyst.sv
// High-priority request with hysteresis on the FIFO level; set wins over clear.
module la_hpri_hyst #(
    parameter int unsigned pLVL_W = 7
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic [pLVL_W-1:0] level,
    input  logic [6:0]        h_thresh,
    input  logic [6:0]        l_thresh,
    input  logic              force_clr,
    output logic              hpri
);
    localparam int unsigned CW = (pLVL_W > 7) ? pLVL_W : 7;

    logic [CW-1:0] lvl_x, h_x, l_x;
    logic          hpri_q, hpri_d;

    assign lvl_x = CW'(level);
    assign h_x   = CW'(h_thresh);
    assign l_x   = CW'(l_thresh);

    // Next request: forced clear, then set, then clear, else hold
    always_comb begin
        hpri_d = hpri_q;
        if (force_clr) begin
            hpri_d = 1'b0;
        end else if (lvl_x >= h_x) begin
            hpri_d = 1'b1;
        end else if (lvl_x <= l_x) begin
            hpri_d = 1'b0;
        end
    end

    // Request register
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            hpri_q <= 1'b0;
        end else begin
            hpri_q <= hpri_d;
        end
    end

    assign hpri = hpri_q;
endmodule

// File: rtl/la_drain_ctrl.sv
// Drain scheduler for the LA RLE trace FIFO: pops fixed-size bursts onto an
// AXIS master with TLAST on the final beat, flushes residue on capture
// disable, and raises a hysteretic high-priority request.
// Optional build macro: LA_DRAIN_TIMEOUT_EN (idle timeout emits partial bursts).
module la_drain_ctrl
    import la_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pLVL_W      = 7
`ifdef LA_DRAIN_TIMEOUT_EN
    ,
    parameter int unsigned pTIMEOUT    = 256
`endif
) (
    input  logic                   axi_clk,
    input  logic                   axi_reset_n,
    input  logic                   cfg_enable,
    input  logic [6:0]             cfg_h_thresh,
    input  logic [6:0]             cfg_l_thresh,
    input  logic [6:0]             cfg_pop_cond,
    input  logic [pLVL_W-1:0]      fifo_level,
    input  logic                   fifo_empty,
    input  logic [pDATA_WIDTH-1:0] fifo_rdata,
    output logic                   fifo_pop,
    la_drain_ctrl_if.master        m,
    output logic                   la_hpri_req,
    output logic                   sts_busy
);
    localparam int unsigned CW = (pLVL_W > CNT_W) ? pLVL_W : CNT_W;

    la_state_e              state_q, state_d;
    logic [CNT_W-1:0]       beats_q, beats_d;
    logic [CNT_W-1:0]       popped_q, popped_d;
    logic [1:0]             kind_q, kind_d;    // tuser of the burst in progress
    logic                   en_q;
    logic [pDATA_WIDTH-1:0] tdata_q;
    logic                   tvalid_q, tlast_q;
    logic [1:0]             tuser_q;

    logic [CNT_W-1:0] pc_eff, lvl_sat;
    logic [CW-1:0]    lvl_x, pc_x;
    logic             lvl_ge_pc, flush_req, pop_last, last_hs, tmo_fire;

    assign pc_eff    = (cfg_pop_cond == 7'd0) ? 7'd1 : cfg_pop_cond;
    assign lvl_x     = CW'(fifo_level);
    assign pc_x      = CW'(pc_eff);
    assign lvl_ge_pc = (lvl_x >= pc_x);
    assign lvl_sat   = sat_cnt(32'(fifo_level));
    assign flush_req = (en_q && !cfg_enable) || (!cfg_enable && !fifo_empty);
    assign last_hs   = tvalid_q && m.tready && tlast_q;
    // In a flush the head word at level 1 is the last one available
    assign pop_last  = ((popped_q + 7'd1) == beats_q) ||
                       ((state_q == FLUSH) && (fifo_level == pLVL_W'(1)));

`ifdef LA_DRAIN_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(pTIMEOUT) + 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_run;

    assign tmo_run  = (state_q == IDLE) && cfg_enable && !fifo_empty && !lvl_ge_pc;
    assign tmo_fire = tmo_run && (tmo_q == TMO_W'(pTIMEOUT - 1));
    assign tmo_d    = tmo_run ? (tmo_q + 1'b1) : '0;

    // Idle residue timer
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // FSM state, burst parameters and enable edge detector
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q  <= IDLE;
            beats_q  <= '0;
            popped_q <= '0;
            kind_q   <= TUSER_NONE;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            beats_q  <= beats_d;
            popped_q <= popped_d;
            kind_q   <= kind_d;
            en_q     <= cfg_enable;
        end
    end

    // Next-state: burst decision in IDLE, return to IDLE on the TLAST handshake
    always_comb begin
        state_d  = state_q;
        beats_d  = beats_q;
        kind_d   = kind_q;
        popped_d = fifo_pop ? (popped_q + 7'd1) : popped_q;
        case (state_q)
            IDLE: begin
                popped_d = '0;
                if (cfg_enable && lvl_ge_pc) begin
                    state_d = BURST;
                    beats_d = pc_eff;
                    kind_d  = TUSER_NONE;
                end else if (flush_req && (lvl_x != '0)) begin
                    state_d = FLUSH;
                    beats_d = lvl_sat;
                    kind_d  = TUSER_FLUSH;
                end else if (tmo_fire) begin
                    state_d = BURST;
                    beats_d = lvl_sat;
                    kind_d  = TUSER_TMO;
                end
            end
            BURST, FLUSH: begin
                if (last_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: pop only when the output register is free or draining
    always_comb begin
        sts_busy = (state_q != IDLE);
        fifo_pop = sts_busy && (popped_q < beats_q) && !fifo_empty &&
                   (!tvalid_q || m.tready);
    end

    // AXIS output register; holds while stalled
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= '0;
        end else if (fifo_pop) begin
            tdata_q  <= fifo_rdata;
            tvalid_q <= 1'b1;
            tlast_q  <= pop_last;
            tuser_q  <= kind_q;
        end else if (m.tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= '0;
        end
    end

    assign m.tdata  = tdata_q;
    assign m.tvalid = tvalid_q;
    assign m.tlast  = tlast_q;
    assign m.tuser  = tuser_q;

    la_hpri_hyst #(
        .pLVL_W (pLVL_W)
    ) u_hpri (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .level       (fifo_level),
        .h_thresh    (cfg_h_thresh),
        .l_thresh    (cfg_l_thresh),
        .force_clr   (!cfg_enable && fifo_empty),
        .hpri        (la_hpri_req)
    );
endmodule
